// File: rtl/stack_memory.sv
// Stack entry storage behind the stack-pointer stage: it clears itself after reset, serves the top of stack, and flags pointer overflow/underflow.
// Optional high-water-mark output STACK_HWM is enabled by defining STACK_HWM_EN.
module stack_memory #(
  parameter int DEPTH_BITS = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              STACK_ENB,
  input  logic              STACK_clear,
  input  logic              STACK_write_flag,
  input  logic [ADDR_W-1:0] STACK_write_addr,
  input  logic [DATA_W-1:0] STACK_write_data,
  output logic [DATA_W-1:0] STACK_data,
  output logic              STACK_READY,
  output logic              STACK_OVERFLOW,
  output logic              STACK_UNDERFLOW
`ifdef STACK_HWM_EN
  ,
  output logic [ADDR_W-1:0] STACK_HWM
`endif
);

  localparam int                DEPTH    = 1 << DEPTH_BITS;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_READY,
    S_FAULT
  } state_t;

  state_t                  state, state_nxt;
  logic [DEPTH_BITS-1:0]   clr_cnt;
  logic [ADDR_W-1:0]       prev_addr;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    addr_in_range;
  logic [DEPTH_BITS-1:0]   idx;
  logic                    underflow_hit;
  logic                    overflow_hit;
  logic                    mem_we;
  logic [DEPTH_BITS-1:0]   mem_wa;
  logic [DATA_W-1:0]       mem_wd;
  logic [DATA_W-1:0]       data_nxt;
  logic                    set_ovf;
  logic                    set_unf;

  // Entry 0 is the empty-stack slot, so it is treated like an out-of-range address.
  assign addr_in_range = (STACK_write_addr != '0) && (STACK_write_addr < DEPTH_A);
  assign idx           = STACK_write_addr[DEPTH_BITS-1:0];
  assign underflow_hit = (prev_addr == '0) && (STACK_write_addr == '1);
  assign overflow_hit  = !underflow_hit && (STACK_write_addr >= DEPTH_A) && (prev_addr < DEPTH_A);

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = '0;
    mem_wd    = '0;
    data_nxt  = STACK_data;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (STACK_clear) begin
      state_nxt = S_CLEAR;
      data_nxt  = '0;
    end else begin
      case (state)
        S_CLEAR: begin
          mem_we   = 1'b1;
          mem_wa   = clr_cnt;
          data_nxt = '0;
          if (clr_cnt == LAST_IDX) state_nxt = S_READY;
        end
        S_READY: begin
          if (STACK_ENB) begin
            if (underflow_hit) begin
              set_unf   = 1'b1;
              state_nxt = S_FAULT;
              data_nxt  = '0;
            end else if (overflow_hit) begin
              set_ovf   = 1'b1;
              state_nxt = S_FAULT;
              data_nxt  = '0;
            end else if (!addr_in_range) begin
              data_nxt = '0;
            end else if (STACK_write_flag) begin
              // Write-through: the new top word appears on STACK_data on the same edge.
              mem_we   = 1'b1;
              mem_wa   = idx;
              mem_wd   = STACK_write_data;
              data_nxt = STACK_write_data;
            end else begin
              data_nxt = mem[idx];
            end
          end
        end
        S_FAULT: data_nxt = '0;
        default: begin
          state_nxt = S_CLEAR;
          data_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_CLEAR;
      clr_cnt         <= '0;
      prev_addr       <= '0;
      STACK_data      <= '0;
      STACK_OVERFLOW  <= 1'b0;
      STACK_UNDERFLOW <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_addr  <= STACK_write_addr;
      STACK_data <= data_nxt;
      if (STACK_clear)            clr_cnt <= '0;
      else if (state == S_CLEAR)  clr_cnt <= clr_cnt + 1'b1;
      if (STACK_clear) begin
        STACK_OVERFLOW  <= 1'b0;
        STACK_UNDERFLOW <= 1'b0;
      end else begin
        if (set_ovf) STACK_OVERFLOW  <= 1'b1;
        if (set_unf) STACK_UNDERFLOW <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign STACK_READY = (state == S_READY);

`ifdef STACK_HWM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      STACK_HWM <= '0;
    end else if (STACK_clear) begin
      STACK_HWM <= '0;
    end else if (state == S_READY && STACK_write_addr < DEPTH_A && STACK_write_addr > STACK_HWM) begin
      STACK_HWM <= STACK_write_addr;
    end
  end
`endif

endmodule

// File: tb/tb_stack_memory.sv
// Directed vector bench for stack_memory with DEPTH_BITS=4: clear sweep, push/pop, write-through, faults, and the optional high-water mark.
module tb_stack_memory;
  localparam int DB = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          enb     = 1'b1;
  logic          clr     = 1'b0;
  logic          wf      = 1'b0;
  logic [AW-1:0] addr    = '0;
  logic [DW-1:0] wdata   = '0;
  logic [DW-1:0] data;
  logic          ready;
  logic          ovf;
  logic          unf;
`ifdef STACK_HWM_EN
  logic [AW-1:0] hwm;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  stack_memory #(.DEPTH_BITS(DB), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .STACK_ENB        (enb),
    .STACK_clear      (clr),
    .STACK_write_flag (wf),
    .STACK_write_addr (addr),
    .STACK_write_data (wdata),
    .STACK_data       (data),
    .STACK_READY      (ready),
    .STACK_OVERFLOW   (ovf),
    .STACK_UNDERFLOW  (unf)
`ifdef STACK_HWM_EN
    ,
    .STACK_HWM        (hwm)
`endif
  );

  typedef struct {
    logic          e;
    logic          c;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] ed;
    logic          er;
    logic          eo;
    logic          eu;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic vec_t mk(logic e_i, logic c_i, logic w_i, logic [AW-1:0] a_i,
                              logic [DW-1:0] wd_i, logic [DW-1:0] ed_i,
                              logic er_i, logic eo_i, logic eu_i);
    vec_t v;
    v.e = e_i; v.c = c_i; v.w = w_i; v.a = a_i; v.wd = wd_i;
    v.ed = ed_i; v.er = er_i; v.eo = eo_i; v.eu = eu_i;
    return v;
  endfunction

  task automatic check_out(input string name, input logic [DW-1:0] ed,
                           input logic er, input logic eo, input logic eu);
    n_vec++;
    if ({data, ready, ovf, unf} !== {ed, er, eo, eu}) begin
      n_err++;
      $display("FAIL %s: got data=%h ready=%b ovf=%b unf=%b, want data=%h ready=%b ovf=%b unf=%b",
               name, data, ready, ovf, unf, ed, er, eo, eu);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clock);
    enb = v.e; clr = v.c; wf = v.w; addr = v.a; wdata = v.wd;
    @(posedge clock);
    #1;
    check_out(name, v.ed, v.er, v.eo, v.eu);
  endtask

  // Counts posedges from now until STACK_READY rises, bounded.
  task automatic wait_ready(input string name, input int exp_n);
    int n;
    n = 0;
    clr = 1'b0;
    wf  = 1'b0;
    while (!ready && n < 64) begin
      @(posedge clock);
      #1;
      n++;
    end
    n_vec++;
    if (n != exp_n || !ready) begin
      n_err++;
      $display("FAIL %s: ready after %0d edges (ready=%b), want %0d", name, n, ready, exp_n);
    end
  endtask

`ifdef STACK_HWM_EN
  task automatic check_hwm(input string name, input logic [AW-1:0] exp);
    n_vec++;
    if (hwm !== exp) begin
      n_err++;
      $display("FAIL %s: hwm=%h want %h", name, hwm, exp);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 1; k < 16; k++) tbl_a.push_back(mk(1, 0, 0, AW'(k), '0, '0, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 0, 16'd0,  32'h0,        32'h0,        1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd1,  32'hAAAA0001, 32'hAAAA0001, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd2,  32'hBBBB0002, 32'hBBBB0002, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 0, 16'd1,  32'h0,        32'hAAAA0001, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 0, 16'd2,  32'h0,        32'hBBBB0002, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd2,  32'hBBBB0002, 32'hBBBB0002, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd2,  32'hBBBB0002, 32'hBBBB0002, 1, 0, 0));
    tbl_a.push_back(mk(0, 0, 1, 16'd1,  32'hDEADBEEF, 32'hBBBB0002, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 0, 16'd1,  32'h0,        32'hAAAA0001, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd0,  32'h12345678, 32'h0,        1, 0, 0));
    tbl_a.push_back(mk(1, 0, 0, 16'd1,  32'h0,        32'hAAAA0001, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd15, 32'hCCCC000F, 32'hCCCC000F, 1, 0, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd16, 32'h99999999, 32'h0,        0, 1, 0));
    tbl_a.push_back(mk(1, 0, 1, 16'd15, 32'h11111111, 32'h0,        0, 1, 0));
    tbl_a.push_back(mk(1, 1, 1, 16'd15, 32'h22222222, 32'h0,        0, 0, 0));

    tbl_b.push_back(mk(1, 0, 0, 16'd15,   32'h0,        32'h0, 1, 0, 0));
    tbl_b.push_back(mk(1, 0, 0, 16'd0,    32'h0,        32'h0, 1, 0, 0));
    tbl_b.push_back(mk(1, 0, 0, 16'hFFFF, 32'h0,        32'h0, 0, 0, 1));
    tbl_b.push_back(mk(1, 0, 1, 16'd1,    32'h55555555, 32'h0, 0, 0, 1));

    #2;
    check_out("reset_state", '0, 0, 0, 0);
`ifdef STACK_HWM_EN
    check_hwm("hwm_reset", '0);
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready("reset_sweep", 16);

    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("vec_a%0d", i));
    wait_ready("clear_sweep", 16);
    foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("vec_b%0d", i));

    #3;
    reset_n = 1'b0;
    addr    = '0;
    wf      = 1'b0;
    #1;
    check_out("async_reset_in_fault", '0, 0, 0, 0);

    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    apply(mk(1, 1, 0, 16'd0, '0, '0, 0, 0, 0), "clear_mid_sweep");
    wait_ready("restarted_sweep", 16);

`ifdef STACK_HWM_EN
    check_hwm("hwm_after_reset", '0);
    apply(mk(1, 0, 1, 16'd1, 32'h1, 32'h1, 1, 0, 0), "hwm_push1");
    apply(mk(1, 0, 1, 16'd2, 32'h2, 32'h2, 1, 0, 0), "hwm_push2");
    apply(mk(1, 0, 1, 16'd3, 32'h3, 32'h3, 1, 0, 0), "hwm_push3");
    apply(mk(1, 0, 0, 16'd1, 32'h0, 32'h1, 1, 0, 0), "hwm_pop1");
    check_hwm("hwm_peak", 16'd3);
    apply(mk(1, 1, 0, 16'd1, 32'h0, 32'h0, 0, 0, 0), "hwm_clear");
    check_hwm("hwm_cleared", '0);
    wait_ready("hwm_clear_sweep", 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
